// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths for the writeback arbiter slice.
// Register-file geometry and writeback source count.
package regfile_wb_arbiter_pkg;
   localparam int RegNumLog2 = 5;
   localparam int RegBusW = 32;
   localparam int WbSrcNum = 3;
   localparam logic RstEnable = 1'b1;
   localparam logic WriteEnable = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Grant is combinational; pointer moves past the winner on adv.
module rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 adv,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] ptr
);
   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic          found;

   // First requester at/after ptr wins, else lowest below ptr
   always_comb begin
      gnt = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      if (rst != RstEnable) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i >= int'(ptr_q)) begin
               found = 1'b1;
               gnt[i] = 1'b1;
               ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
               found = 1'b1;
               gnt[i] = 1'b1;
               ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
            end
         end
         if (!adv) ptr_d = ptr_q;
      end
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (rst == RstEnable) ptr_q <= '0;
      else                  ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter in front of the register file.
// Round-robin grant, one registered write per cycle, hazard query.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = WbSrcNum,
   parameter int ADDR_W = RegNumLog2,
   parameter int DATA_W = RegBusW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*ADDR_W-1:0] src_waddr,
   input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   input  logic [ADDR_W-1:0]         qry_addr,
   output logic                      qry_hit,
   output logic                      busy
);
   logic [NUM_SRC-1:0]         gnt;
   logic [$clog2(NUM_SRC)-1:0] rr_ptr;
   logic                       any_gnt;
   logic [ADDR_W-1:0]          sel_waddr;
   logic [DATA_W-1:0]          sel_wdata;
   logic                       src_hit;
   logic                       rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]          rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]          rf_wdata_q, rf_wdata_d;

   rr_arbiter #(.N(NUM_SRC)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (src_valid),
      .adv (1'b1),
      .gnt (gnt),
      .ptr (rr_ptr)
   );

   assign src_ready = gnt;
   assign any_gnt = |gnt;

   // AND-OR mux of the granted source
   always_comb begin
      sel_waddr = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sel_waddr |= src_waddr[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt[i]}};
         sel_wdata |= src_wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}};
      end
   end

   // Next output-stage write; writes to $zero are dropped
   always_comb begin
      rf_we_d = ~WriteEnable;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (any_gnt) begin
         rf_we_d = (sel_waddr != '0) ? WriteEnable : ~WriteEnable;
         rf_waddr_d = sel_waddr;
         rf_wdata_d = sel_wdata;
      end
   end

   // Output-stage register
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         rf_we_q <= ~WriteEnable;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Hazard query over requests and the output stage
   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_valid[i] && src_waddr[i*ADDR_W +: ADDR_W] == qry_addr)
            src_hit = 1'b1;
      end
      qry_hit = (rst != RstEnable) && (qry_addr != '0) &&
                (src_hit || (rf_we_q && rf_waddr_q == qry_addr));
   end

   assign busy = (rst != RstEnable) && ((|src_valid) || rf_we_q);
   assign rf_we = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

   a_ptr_range: assert property (@(posedge clk) disable iff (rst)
      int'(rr_ptr) < NUM_SRC);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Directed table, corner sequences, then random vs. reference model.
module tb_regfile_wb_arbiter;
   logic        clk;
   logic        rst;
   logic [2:0]  src_valid;
   logic [14:0] src_waddr;
   logic [95:0] src_wdata;
   logic [2:0]  src_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  qry_addr;
   logic        qry_hit;
   logic        busy;

   regfile_wb_arbiter #(.NUM_SRC(3), .ADDR_W(5), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_waddr (src_waddr),
      .src_wdata (src_wdata),
      .src_ready (src_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .qry_addr  (qry_addr),
      .qry_hit   (qry_hit),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] v;
      logic [4:0] a0, a1, a2, q;
      logic [2:0] rdy;
      logic       hit;
      int         src;
   } vec_t;

   localparam int NV = 11;
   vec_t vt[NV];

   int total = 0;
   int passed = 0;
   logic        e_we;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [31:0] dat(input int i, input logic [4:0] a);
      return 32'hC0DE_0000 | (32'(i) << 8) | 32'(a);
   endfunction

   task automatic drive(input logic [2:0] v, input logic [4:0] a0,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] q);
      src_valid = v;
      src_waddr = {a2, a1, a0};
      src_wdata = {dat(2, a2), dat(1, a1), dat(0, a0)};
      qry_addr = q;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rf(input string nm);
      chk({nm, "_we"}, 32'(rf_we), 32'(e_we));
      chk({nm, "_waddr"}, 32'(rf_waddr), 32'(e_waddr));
      chk({nm, "_wdata"}, rf_wdata, e_wdata);
   endtask

   logic        pend[3];
   logic [4:0]  pa[3];
   logic [31:0] pd[3];
   int          m_ptr;
   int          g;
   int          j;
   logic        eh;
   logic [4:0]  q;
   logic [4:0]  sa;

   initial begin
      vt[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 5'd3, 3'b001, 1'b1, 0};
      vt[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 5'd1, 3'b010, 1'b1, 1};
      vt[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 5'd9, 3'b100, 1'b0, 2};
      vt[3]  = '{3'b000, 5'd1, 5'd2, 5'd3, 5'd3, 3'b000, 1'b1, -1};
      vt[4]  = '{3'b010, 5'd0, 5'd5, 5'd0, 5'd5, 3'b010, 1'b1, 1};
      vt[5]  = '{3'b001, 5'd4, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 0};
      vt[6]  = '{3'b100, 5'd0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b0, 2};
      vt[7]  = '{3'b011, 5'd6, 5'd6, 5'd0, 5'd6, 3'b001, 1'b1, 0};
      vt[8]  = '{3'b010, 5'd6, 5'd6, 5'd0, 5'd6, 3'b010, 1'b1, 1};
      vt[9]  = '{3'b000, 5'd6, 5'd6, 5'd0, 5'd6, 3'b000, 1'b1, -1};
      vt[10] = '{3'b000, 5'd6, 5'd6, 5'd0, 5'd6, 3'b000, 1'b0, -1};

      rst = 1'b1;
      drive(3'b111, 5'd1, 5'd2, 5'd3, 5'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy", 32'(src_ready), 32'd0);
      chk("rst_hit", 32'(qry_hit), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      e_we = 1'b0;
      e_waddr = '0;
      e_wdata = '0;
      chk_rf("rst");
      rst = 1'b0;

      for (int k = 0; k < NV; k++) begin
         drive(vt[k].v, vt[k].a0, vt[k].a1, vt[k].a2, vt[k].q);
         #1;
         chk("tbl_rdy", 32'(src_ready), 32'(vt[k].rdy));
         chk("tbl_hit", 32'(qry_hit), 32'(vt[k].hit));
         chk("tbl_busy", 32'(busy), 32'((|vt[k].v) || e_we));
         if (vt[k].src >= 0) begin
            sa = (vt[k].src == 0) ? vt[k].a0 :
                 (vt[k].src == 1) ? vt[k].a1 : vt[k].a2;
            e_we = (sa != 5'd0);
            e_waddr = sa;
            e_wdata = dat(vt[k].src, sa);
         end else begin
            e_we = 1'b0;
         end
         cyc();
         chk_rf("tbl");
      end

      drive(3'b010, 5'd0, 5'd5, 5'd0, 5'd0);
      src_wdata[63:32] = 32'hDEADBEEF;
      #1;
      chk("single_rdy", 32'(src_ready), 32'b010);
      cyc();
      e_we = 1'b1; e_waddr = 5'd5; e_wdata = 32'hDEADBEEF;
      chk_rf("single_n1");
      drive(3'b000, 5'd0, 5'd0, 5'd0, 5'd0);
      cyc();
      e_we = 1'b0;
      chk_rf("single_n2");

      rst = 1'b1;
      cyc();
      rst = 1'b0;
      drive(3'b111, 5'd1, 5'd2, 5'd3, 5'd0);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("cont_rdy", 32'(src_ready), 32'(1) << (i % 3));
         cyc();
         chk("cont_we", 32'(rf_we), 32'd1);
         chk("cont_waddr", 32'(rf_waddr), 32'((i % 3) + 1));
      end
      drive(3'b000, 5'd0, 5'd0, 5'd0, 5'd0);
      cyc();
      chk("cont_idle_we", 32'(rf_we), 32'd0);

      drive(3'b100, 5'd0, 5'd0, 5'd0, 5'd0);
      src_wdata[95:64] = 32'h1234;
      #1;
      chk("zero_rdy", 32'(src_ready), 32'b100);
      chk("zero_hit", 32'(qry_hit), 32'd0);
      cyc();
      e_we = 1'b0; e_waddr = 5'd0; e_wdata = 32'h1234;
      chk_rf("zero");

      drive(3'b001, 5'd7, 5'd0, 5'd0, 5'd7);
      #1;
      chk("haz_hit7", 32'(qry_hit), 32'd1);
      chk("haz_rdy", 32'(src_ready), 32'b001);
      qry_addr = 5'd8;
      #1;
      chk("haz_hit8", 32'(qry_hit), 32'd0);
      qry_addr = 5'd7;
      cyc();
      drive(3'b000, 5'd0, 5'd0, 5'd0, 5'd7);
      #1;
      chk("haz_hit_we", 32'(qry_hit), 32'd1);
      chk("haz_we", 32'(rf_we), 32'd1);
      cyc();
      chk("haz_hit_end", 32'(qry_hit), 32'd0);

      drive(3'b010, 5'd0, 5'd9, 5'd0, 5'd0);
      #1;
      chk("rstmid_rdy", 32'(src_ready), 32'b010);
      rst = 1'b1;
      #1;
      chk("rstmid_rdy_rst", 32'(src_ready), 32'd0);
      cyc();
      e_we = 1'b0; e_waddr = '0; e_wdata = '0;
      chk_rf("rstmid");
      rst = 1'b0;
      drive(3'b111, 5'd1, 5'd2, 5'd3, 5'd0);
      #1;
      chk("rstmid_ptr0", 32'(src_ready), 32'b001);
      drive(3'b000, 5'd0, 5'd0, 5'd0, 5'd0);
      cyc();
      chk_rf("rstmid_idle");

      m_ptr = 0;
      for (int i = 0; i < 3; i++) begin
         pend[i] = 1'b0; pa[i] = '0; pd[i] = '0;
      end
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               pa[i] = 5'($urandom_range(0, 7));
               pd[i] = $urandom;
            end
            src_valid[i] = pend[i];
            src_waddr[i*5 +: 5] = pa[i];
            src_wdata[i*32 +: 32] = pd[i];
         end
         q = 5'($urandom_range(0, 7));
         qry_addr = q;
         #1;
         g = -1;
         for (int k = 0; k < 3; k++) begin
            j = (m_ptr + k) % 3;
            if (g < 0 && pend[j]) g = j;
         end
         eh = 1'b0;
         if (q != 5'd0) begin
            if (e_we && e_waddr == q) eh = 1'b1;
            for (int i = 0; i < 3; i++)
               if (pend[i] && pa[i] == q) eh = 1'b1;
         end
         chk("rnd_rdy", 32'(src_ready), (g < 0) ? 32'd0 : (32'(1) << g));
         chk("rnd_hit", 32'(qry_hit), 32'(eh));
         chk("rnd_busy", 32'(busy),
             32'(pend[0] || pend[1] || pend[2] || e_we));
         if (g >= 0) begin
            e_we = (pa[g] != 5'd0);
            e_waddr = pa[g];
            e_wdata = pd[g];
            pend[g] = 1'b0;
            m_ptr = (g + 1) % 3;
         end else begin
            e_we = 1'b0;
         end
         cyc();
         chk_rf("rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
